// File: rtl/risc15_pkg.sv
// Shared types and constants for the 16-bit multicycle RISC core.
// Holds the LM/SM sequencer state encoding and the core's width constants.
package risc15_pkg;

    localparam int DATA_W  = 16;
    localparam int REG_CNT = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } lmsm_state_t;

endpackage

// File: rtl/lsb_pick_enc.sv
// Lowest-set-bit priority encoder.
// Also flags when exactly one bit is set.
module lsb_pick_enc #(
    parameter int REG_CNT = 8
) (
    input  logic [REG_CNT-1:0]         vec,
    output logic [$clog2(REG_CNT)-1:0] idx,
    output logic                       one_hot_last
);

    localparam int IW = $clog2(REG_CNT);

    always_comb begin
        idx = '0;
        // Scan downwards so the lowest set bit is the final assignment.
        for (int i = REG_CNT - 1; i >= 0; i--) begin
            if (vec[i]) idx = i[IW-1:0];
        end
    end

    assign one_hot_last = (vec != '0) && ((vec & (vec - REG_CNT'(1))) == '0);

endmodule

// File: rtl/lmsm_sequencer.sv
// Load/store-multiple register-list sequencer: walks the set bits of the
// register list in ascending order, one transfer per acknowledged step.
module lmsm_sequencer #(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 8,
    parameter int IDX_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      is_store,
    input  logic [DATA_W-1:0]         base_addr,
    input  logic [REG_CNT-1:0]        reg_list,
    input  logic                      step_ack,
    output logic                      busy,
    output logic                      step_valid,
    output logic [IDX_W-1:0]          reg_idx,
    output logic [DATA_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic                      rf_we,
    output logic                      last,
    output logic                      done,
    output logic [IDX_W:0]            xfer_cnt,
    output risc15_pkg::lmsm_state_t   state
);

    import risc15_pkg::*;

    localparam int CW = IDX_W + 1;

    logic [REG_CNT-1:0] pending;
    logic [DATA_W-1:0]  addr_q;
    logic               is_store_q;
    logic [CW-1:0]      xfer_cnt_q;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_last;

    lsb_pick_enc #(.REG_CNT(REG_CNT)) u_enc (
        .vec          (pending),
        .idx          (enc_idx),
        .one_hot_last (enc_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= '0;
            addr_q     <= '0;
            is_store_q <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pending    <= reg_list;
                        addr_q     <= base_addr;
                        is_store_q <= is_store;
                        xfer_cnt_q <= '0;
                        state      <= (reg_list != '0) ? STEP : DONE;
                    end
                end
                STEP: begin
                    if (step_ack) begin
                        // Clearing the lowest set bit retires the current register.
                        pending    <= pending & (pending - REG_CNT'(1));
                        addr_q     <= addr_q + DATA_W'(1);
                        xfer_cnt_q <= xfer_cnt_q + CW'(1);
                        if (enc_last) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign step_valid = (state == STEP);
    assign busy       = (state == STEP) || (state == DONE);
    assign done       = (state == DONE);
    assign reg_idx    = step_valid ? enc_idx : '0;
    assign mem_addr   = step_valid ? addr_q : '0;
    assign mem_we     = step_valid & is_store_q;
    assign rf_we      = step_valid & ~is_store_q & step_ack;
    assign last       = step_valid & enc_last;
    assign xfer_cnt   = xfer_cnt_q;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Self-checking bench for lmsm_sequencer: a reference model queues the
// expected transfers at start, and each observed step is checked against it.
module tb_lmsm_sequencer;

    import risc15_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [15:0] base_addr = '0;
    logic [7:0]  reg_list = '0;
    logic        step_ack = 1'b0;
    logic        busy, step_valid, mem_we, rf_we, last, done;
    logic [2:0]  reg_idx;
    logic [15:0] mem_addr;
    logic [3:0]  xfer_cnt;
    lmsm_state_t state;

    int total = 0;
    int bad   = 0;

    // Entry layout: {reg_idx[2:0], mem_addr[15:0], mem_we, last}
    logic [20:0] exp_q[$];
    logic        exp_store;
    int          exp_cnt;

    always #5 clk = ~clk;

    lmsm_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .base_addr(base_addr), .reg_list(reg_list), .step_ack(step_ack),
        .busy(busy), .step_valid(step_valid), .reg_idx(reg_idx),
        .mem_addr(mem_addr), .mem_we(mem_we), .rf_we(rf_we), .last(last),
        .done(done), .xfer_cnt(xfer_cnt), .state(state)
    );

    // Drive a start and push the model's expected transfer list.
    task automatic drive_start(input logic st, input logic [15:0] base, input logic [7:0] list);
        int n;
        int bits;
        logic [15:0] a;
        @(negedge clk);
        start = 1'b1; is_store = st; base_addr = base; reg_list = list;
        exp_q.delete();
        exp_store = st;
        bits = 0;
        for (int i = 0; i < 8; i++) if (list[i]) bits++;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (list[i]) begin
                a = base + 16'(n);
                n++;
                exp_q.push_back({3'(i), a, st, (n == bits)});
            end
        end
        exp_cnt = bits;
    endtask

    // Run the sequence to done. mode 0: ack held high, mode 1: ack toggles 1,0.
    // inject_at > 0 asserts a conflicting start on that cycle.
    task automatic drain(input int mode, input int exp_done_cyc, input int inject_at);
        int cyc;
        int steps;
        logic [20:0] e;
        logic [20:0] obs;
        cyc = 0;
        steps = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == inject_at) begin
                start = 1'b1; reg_list = 8'h01; is_store = ~exp_store; base_addr = 16'h1234;
            end
            step_ack = (mode == 0) ? 1'b1 : ((steps % 2) == 0);
            #1;
            total++;
            if (busy !== (step_valid | done)) begin
                bad++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, step_valid | done);
            end
            if (step_valid) begin
                steps++;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_step cyc=%0d idx=%0d addr=%h", cyc, reg_idx, mem_addr);
                end else begin
                    e = exp_q[0];
                    obs = {reg_idx, mem_addr, mem_we, last};
                    total++;
                    if (obs !== e) begin
                        bad++;
                        $display("FAIL step cyc=%0d got idx=%0d addr=%h we=%b last=%b want idx=%0d addr=%h we=%b last=%b",
                                 cyc, obs[20:18], obs[17:2], obs[1], obs[0], e[20:18], e[17:2], e[1], e[0]);
                    end
                    total++;
                    if (rf_we !== (~exp_store & step_ack)) begin
                        bad++;
                        $display("FAIL rf_we cyc=%0d got=%b want=%b", cyc, rf_we, ~exp_store & step_ack);
                    end
                    if (step_ack) void'(exp_q.pop_front());
                end
            end
            if (done) break;
            if (cyc > 60) begin
                total++; bad++;
                $display("FAIL timeout waiting for done cyc=%0d", cyc);
                break;
            end
        end
        step_ack = 1'b0;
        if (exp_done_cyc > 0) begin
            total++;
            if (cyc !== exp_done_cyc) begin
                bad++;
                $display("FAIL done_latency got=%0d want=%0d", cyc, exp_done_cyc);
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_steps left=%0d want=0", exp_q.size());
        end
        total++;
        if (xfer_cnt !== 4'(exp_cnt)) begin
            bad++;
            $display("FAIL xfer_cnt got=%0d want=%0d", xfer_cnt, exp_cnt);
        end
        @(negedge clk);
        #1;
        total++;
        if (state !== IDLE || done !== 1'b0 || xfer_cnt !== 4'(exp_cnt)) begin
            bad++;
            $display("FAIL post_done state=%0d done=%b cnt=%0d want state=0 done=0 cnt=%0d",
                     state, done, xfer_cnt, exp_cnt);
        end
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if ({busy, step_valid, reg_idx, mem_addr, mem_we, rf_we, last, done, xfer_cnt} !== '0 ||
            state !== IDLE) begin
            bad++;
            $display("FAIL %s outputs busy=%b sv=%b idx=%0d addr=%h we=%b rf=%b last=%b done=%b cnt=%0d state=%0d want all 0",
                     name, busy, step_valid, reg_idx, mem_addr, mem_we, rf_we, last, done, xfer_cnt, state);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
    endtask

    task automatic test_mixed_lm();
        drive_start(1'b0, 16'h0040, 8'b1010_0101);
        drain(0, 5, 0);
    endtask

    task automatic test_empty();
        drive_start(1'b0, 16'h0100, 8'h00);
        drain(0, 1, 0);
    endtask

    task automatic test_full_sm_wrap();
        drive_start(1'b1, 16'hFFFE, 8'hFF);
        drain(1, 0, 0);
    endtask

    task automatic test_start_busy();
        drive_start(1'b0, 16'h0200, 8'b0011_0010);
        drain(0, 4, 2);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            drive_start(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                        8'($urandom_range(0, 255)));
            drain(int'($urandom_range(0, 1)), 0, 0);
        end
    endtask

    task automatic test_reset_mid();
        drive_start(1'b1, 16'h0300, 8'b0000_1110);
        @(negedge clk);
        start = 1'b0;
        step_ack = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (step_valid !== 1'b1 || reg_idx !== 3'd2 || mem_addr !== 16'h0301) begin
            bad++;
            $display("FAIL reset_mid_step2 sv=%b idx=%0d addr=%h want sv=1 idx=2 addr=0301",
                     step_valid, reg_idx, mem_addr);
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("reset_mid");
        rst_n = 1'b1;
        step_ack = 1'b0;
        test_mixed_lm();
    endtask

    initial begin
        test_reset();
        test_mixed_lm();
        test_empty();
        test_full_sm_wrap();
        test_start_busy();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Multi-cycle register-list sequencer for the 16-bit multicycle RISC processor's load-multiple (LM) and store-multiple (SM) instructions. It sits between the controller and the datapath. It replaces the bare 3-bit step counter passed between them. For each set bit of the instruction's 8-bit register list, it produces the register index, the word address and the write strobe, one transfer per acknowledged step, in ascending register order.

## Interface
Parameters:
- `DATA_W`, 16: address and data width.
- `REG_CNT`, 8: number of architectural registers, which is also the register-list width.
- `IDX_W`, 3: register index width, equal to clog2(REG_CNT).

Ports:
- `clk`, in, 1: single system clock. All state changes on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset. Sampled on the rising edge of `clk`.
- `start`, in, 1: request a new sequence. Honoured only in IDLE.
- `is_store`, in, 1: 1 = SM (memory write), 0 = LM (register-file write). Latched on `start`.
- `base_addr`, in, DATA_W: address of the first transfer. Latched on `start`.
- `reg_list`, in, REG_CNT: register list from IR[7:0]. Bit i selects register i. Latched on `start`.
- `step_ack`, in, 1: the controller/datapath has completed the current transfer.
- `busy`, out, 1: high in STEP and DONE.
- `step_valid`, out, 1: a transfer is presented. High exactly in STEP.
- `reg_idx`, out, IDX_W: register for the current transfer.
- `mem_addr`, out, DATA_W: memory address for the current transfer.
- `mem_we`, out, 1: `step_valid & is_store_q`.
- `rf_we`, out, 1: `step_valid & ~is_store_q & step_ack`.
- `last`, out, 1: `step_valid` and exactly one bit still pending.
- `done`, out, 1: one-cycle pulse marking the end of the sequence.
- `xfer_cnt`, out, IDX_W+1: number of transfers completed in the current or most recent sequence.

## Operation
States: IDLE, STEP, DONE.

**IDLE**
- `start=1` latches `reg_list` into `pending`, `base_addr` into `addr_q`, and `is_store` into `is_store_q`, and clears `xfer_cnt`.
- Next state is STEP if `reg_list != 0`, otherwise DONE. An empty list performs zero transfers.
- `start=0` holds IDLE.

**STEP**
- `reg_idx` is the index of the least-significant set bit of `pending`.
- `mem_addr` equals `addr_q`.
- On `step_ack`:
  - clear that bit of `pending`;
  - increment `addr_q` by 1, modulo 2^DATA_W, so 16'hFFFF wraps to 16'h0000;
  - increment `xfer_cnt`.
- If the acked step was `last`, go to DONE. Otherwise stay in STEP.
- Without `step_ack`, all outputs hold stable.

**DONE**
- `done=1` for exactly one cycle, then go to IDLE.
- `xfer_cnt` holds its final value until the next accepted `start`.

**Boundary and override rules**
- `start` while busy is ignored. Latched values are unchanged.
- `step_ack` outside STEP is ignored.
- `reg_list = 8'hFF` gives 8 transfers, with `xfer_cnt` reaching 8. This is why `xfer_cnt` is IDX_W+1 bits.
- Reset has priority over everything, including a mid-sequence `step_ack`. The cycle after `rst_n=0` is sampled:
  - state is IDLE;
  - `pending=0`, `addr_q=0`, `is_store_q=0`, `xfer_cnt=0`;
  - all outputs are 0.
- No partial transfer is retried after reset.

## Timing
- Output reset values: `busy`, `step_valid`, `reg_idx`, `mem_addr`, `mem_we`, `rf_we`, `last`, `done` and `xfer_cnt` are all 0.
- Latency:
  - `start` sampled at edge N gives `step_valid=1` after edge N.
  - An empty list gives `done=1` after edge N instead.
- Throughput is one transfer per cycle with `step_ack` held high.
- Duration:
  - A list with k set bits takes k+1 cycles from `start` to `done` (minimum ack-delay case).
  - With the empty list, `done` follows `start` by 1 cycle.
- Output sources:
  - `reg_idx`, `mem_addr`, `mem_we`, `last` and `step_valid` are decoded from registered state and are glitch-stable within a cycle.
  - `rf_we` is combinational on `step_ack`.
- A back-to-back `start` is accepted in the cycle after `done`, once in IDLE.

## Structure
- Shared package `risc15_pkg` holds:
  - the state enum `lmsm_state_t` (IDLE, STEP, DONE);
  - constants `DATA_W=16`, `REG_CNT=8`, `IDX_W=3`.
- Sub-module `lsb_pick_enc`: combinational lowest-set-bit priority encoder with parameter REG_CNT.
  - Inputs: `vec`.
  - Outputs: `idx` and `one_hot_last` (popcount(vec)==1).

## Test plan
- **Mixed list, LM:** reset, then `start` with `reg_list=8'b1010_0101`, `base=16'h0040`, LM, `step_ack` held 1.
  - Required: `reg_idx` 0,2,5,7 on consecutive cycles, with `mem_addr` 40,41,42,43.
  - `rf_we` high on all 4 steps; `last` only on idx 7; `done` on the next cycle; `xfer_cnt=4`.
- **Empty list:** `reg_list=0`.
  - Required: no `step_valid`, `done` 1 cycle after `start`, `xfer_cnt=0`.
- **Full list, SM with wrap:** `reg_list=8'hFF`, SM, `base=16'hFFFE`, `step_ack` toggling 1,0.
  - Required: 8 steps; `mem_addr` FFFE, FFFF, 0000 … 0005; `mem_we` high throughout STEP.
  - Outputs stable during the ack=0 cycles; `xfer_cnt=8`.
- **`start` while busy:** during the previous sequence, assert `start` with `reg_list=8'h01`.
  - Required: ignored; the original sequence completes unchanged.
- **Reset mid-sequence:** `rst_n=0` during step 2 of an SM, with `step_ack` also asserted.
  - Required: all outputs 0 the next cycle and state IDLE.
  - A new `start` is then accepted normally.
